// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the handshaked data-memory responder:
// funct3 encodings, FSM state type and access-legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Size is carried in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic ill;
    ill = 1'b0;
    if (we) begin
      ill = (funct3 > F3_W);
    end else begin
      ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end
    return ill;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core's load/store port and the
// data-memory responder.
interface dmem_responder_if #(
  parameter int D_WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [D_WIDTH-1:0] req_wdata;
  logic [2:0]         req_funct3;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [D_WIDTH-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_load_store_align.sv
// Byte-lane steering for RV32 loads and stores: write enables plus
// replicated store data, and extraction/extension of load data.
module load_store_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rword >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Store lanes: data is replicated so each enabled lane sees its byte.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_rdata = i_rword;
      F3_BU:   o_rdata = {24'h00_0000, w_byte};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory behind a valid/ready request/response channel,
// with LATENCY wait states between acceptance and the array access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int A_WIDTH = 17,
  parameter int D_WIDTH = 32,
  parameter int LATENCY = 2
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);

  localparam int         DEPTH = 2 ** (A_WIDTH - 2);
  localparam logic [3:0] LAT   = LATENCY[3:0];

  dmem_state_t        r_state;
  dmem_state_t        w_next;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [2:0]         r_f3;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [D_WIDTH-1:0] r_rsp_rdata;
  logic               r_rsp_err;

  logic [7:0]         r_mem [4][DEPTH];

  logic               w_accept;
  logic               w_acc_en;
  logic               w_acc_we;
  logic [A_WIDTH-1:0] w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic [2:0]         w_acc_f3;
  logic               w_acc_err;
  logic               w_wr_en;
  logic [A_WIDTH-3:0] w_idx;
  logic [31:0]        w_rword;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_sh;
  logic [31:0]        w_ld_data;
  logic               w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[31:A_WIDTH];
  assign w_accept      = bus.req_valid && r_req_ready && (r_state == IDLE);

  // With zero wait states the access happens on the acceptance edge, so the
  // live request is used instead of the holding registers.
  assign w_acc_we    = (r_state == IDLE) ? bus.req_we                 : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? bus.req_addr[A_WIDTH-1:0]  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.req_wdata              : r_wdata;
  assign w_acc_f3    = (r_state == IDLE) ? bus.req_funct3             : r_f3;

  assign w_acc_en  = (w_accept && (LAT == 4'd0)) || ((r_state == WAIT) && (r_cnt <= 4'd1));
  assign w_acc_err = is_misaligned(w_acc_f3, w_acc_addr[1:0]) || is_illegal(w_acc_we, w_acc_f3);
  assign w_wr_en   = w_acc_en && w_acc_we && !w_acc_err;

  assign w_idx   = w_acc_addr[A_WIDTH-1:2];
  assign w_rword = {r_mem[3][w_idx], r_mem[2][w_idx], r_mem[1][w_idx], r_mem[0][w_idx]};

  load_store_align u_align (
    .i_funct3  (w_acc_f3),
    .i_addr_lo (w_acc_addr[1:0]),
    .i_wdata   (w_acc_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_ld_data)
  );

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (LAT == 4'd0) ? RESP : WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = RESP;
        end else begin
          w_next = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Holding registers and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= 3'b000;
    end else if (w_accept) begin
      r_cnt   <= LAT;
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr[A_WIDTH-1:0];
      r_wdata <= bus.req_wdata;
      r_f3    <= bus.req_funct3;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered channel outputs; response payload is captured at the access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);
      if (w_acc_en) begin
        r_rsp_err   <= w_acc_err;
        r_rsp_rdata <= (w_acc_we || w_acc_err) ? 32'h0000_0000 : w_ld_data;
      end else if ((r_state == RESP) && bus.rsp_ready) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  // Byte-lane storage; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[i][w_idx] <= w_wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        va, vb, rra, rrb;
  int          n_cmp;
  int          n_err;
  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  assign bus_a.req_valid  = va;
  assign bus_a.req_we     = t_we;
  assign bus_a.req_addr   = t_addr;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_a.req_funct3 = t_f3;
  assign bus_a.rsp_ready  = rra;
  assign bus_b.req_valid  = vb;
  assign bus_b.req_we     = t_we;
  assign bus_b.req_addr   = t_addr;
  assign bus_b.req_wdata  = t_wdata;
  assign bus_b.req_funct3 = t_f3;
  assign bus_b.rsp_ready  = rrb;

  dmem_responder #(.A_WIDTH(17), .D_WIDTH(32), .LATENCY(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dmem_responder #(.A_WIDTH(17), .D_WIDTH(32), .LATENCY(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request/response; hold = extra RESP cycles with rsp_ready low.
  task automatic txn(input bit sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] o_rd, output logic o_er, output int o_lat);
    int guard;
    @(negedge clk);
    t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wd;
    if (sel) vb = 1'b1; else va = 1'b1;
    guard = 0;
    while (!(sel ? bus_b.req_ready : bus_a.req_ready) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_before_accept", {31'd0, (sel ? bus_b.req_ready : bus_a.req_ready)}, 32'd1);
    @(negedge clk);
    va = 1'b0; vb = 1'b0;
    t_addr = 32'hFFFF_FFFC; t_wdata = ~wd; t_f3 = 3'b111; t_we = ~we;
    o_lat = 1;
    while (!(sel ? bus_b.rsp_valid : bus_a.rsp_valid) && o_lat < 40) begin
      @(negedge clk);
      o_lat++;
    end
    o_rd = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    o_er = sel ? bus_b.rsp_err : bus_a.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
      chk("hold_rdata", bus_a.rsp_rdata, o_rd);
      chk("hold_err", {31'd0, bus_a.rsp_err}, {31'd0, o_er});
      chk("hold_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    end
    if (sel) rrb = 1'b1; else rra = 1'b1;
    @(negedge clk);
    rra = 1'b0; rrb = 1'b0;
    chk("post_rsp_valid", {31'd0, (sel ? bus_b.rsp_valid : bus_a.rsp_valid)}, 32'd0);
    chk("post_req_ready", {31'd0, (sel ? bus_b.req_ready : bus_a.req_ready)}, 32'd1);
    chk("post_rdata", (sel ? bus_b.rsp_rdata : bus_a.rsp_rdata), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; va = 1'b0; vb = 1'b0; rra = 1'b0; rrb = 1'b0;
    t_we = 1'b0; t_f3 = 3'b000; t_addr = 32'd0; t_wdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, bus_a.req_ready}, 32'd1);

    // Word store/load with LATENCY=2
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", {31'd0, er}, 32'd0);
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, rd, er, lat);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_err", {31'd0, er}, 32'd0);

    // Sign/zero extension
    txn(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_5680, 0, rd, er, lat);
    txn(1'b0, 1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, rd, er, lat);
    chk("lb", rd, 32'hFFFF_FF80);
    txn(1'b0, 1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, rd, er, lat);
    chk("lbu", rd, 32'h0000_0080);
    txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_8001, 0, rd, er, lat);
    txn(1'b0, 1'b0, 3'b001, 32'h0000_0202, 32'd0, 0, rd, er, lat);
    chk("lh", rd, 32'hFFFF_8001);
    txn(1'b0, 1'b0, 3'b101, 32'h0000_0202, 32'd0, 0, rd, er, lat);
    chk("lhu", rd, 32'h0000_8001);

    // Misalignment and illegal funct3
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h1111_1111, 0, rd, er, lat);
    chk("sw_mis_err", {31'd0, er}, 32'd1);
    chk("sw_mis_rdata", rd, 32'd0);
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, rd, er, lat);
    chk("lw_after_mis", rd, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 3'b001, 32'h0000_0101, 32'd0, 0, rd, er, lat);
    chk("lh_mis_err", {31'd0, er}, 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
    txn(1'b0, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 0, rd, er, lat);
    chk("ld_f3_011_err", {31'd0, er}, 32'd1);
    txn(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 0, rd, er, lat);
    chk("st_f3_100_err", {31'd0, er}, 32'd1);
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 5, rd, er, lat);
    chk("backpressure_rdata", rd, 32'hDEAD_BEEF);

    // Reset in the middle of WAIT drops the store
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0000_0000, 0, rd, er, lat);
    @(negedge clk);
    t_we = 1'b1; t_f3 = 3'b010; t_addr = 32'h0000_0040; t_wdata = 32'h1234_5678; va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("midrst_rdata", bus_a.rsp_rdata, 32'd0);
    chk("midrst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_rst_no_rsp", {31'd0, bus_a.rsp_valid}, 32'd0);
    end
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 0, rd, er, lat);
    chk("lw_after_rst", rd, 32'd0);

    // LATENCY=0 and address wrap
    txn(1'b1, 1'b1, 3'b000, 32'h0001_FFFF, 32'h0000_00AA, 0, rd, er, lat);
    chk("lat0_sb_lat", 32'(lat), 32'd1);
    chk("lat0_sb_err", {31'd0, er}, 32'd0);
    txn(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd0, 0, rd, er, lat);
    chk("lat0_lbu_lat", 32'(lat), 32'd1);
    chk("lat0_lbu_wrap", rd, 32'h0000_00AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the datapath's load/store port. It replaces the single-cycle combinational data memory with a handshaked, multi-cycle data memory.
- It accepts one request at a time on a valid/ready channel. It performs the byte, half or word access selected by funct3, then returns load data or a store acknowledge on a response channel.
- It models a slow memory, such as an external SRAM or a future cache backing store, so the core's stall logic can be exercised against it.

Parameters:
- A_WIDTH, 17: number of byte-address bits actually stored. The memory holds 2^A_WIDTH bytes and higher address bits are ignored.
- D_WIDTH, 32: data width. Fixed at 32; RV32 semantics.
- LATENCY, 2: wait-state cycles between request acceptance and the memory access. Legal range is 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  D_WIDTH  store data (rs2), right-aligned.
- req_funct3  in  3  access size/sign, per RV32I load/store funct3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  D_WIDTH  load result, already extended. 0 for stores and for errors.
- rsp_err  out  1  misaligned access or illegal funct3.

Behaviour:
- Reset: async on rst_n low.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - FSM goes to IDLE.
  - Memory array is NOT reset; contents survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture we, addr[A_WIDTH-1:0], wdata and funct3 into holding registers, and load the wait counter with LATENCY.
  - If LATENCY==0, go to RESP directly: the access occurs on the acceptance edge and the response appears the next cycle. Otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements by 1 each cycle.
  - When the counter reaches 1, the access is performed on that edge and the FSM goes to RESP.
  - Accept-to-rsp_valid latency is LATENCY+1 cycles.
- Access, performed exactly once per request:
  - Load funct3 codes:
    - 000 LB: sign-extend byte.
    - 001 LH: sign-extend half.
    - 010 LW.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend half.
  - Store funct3 codes:
    - 000 SB: writes wdata[7:0].
    - 001 SH: writes wdata[15:0].
    - 010 SW.
  - Byte order is little-endian; the byte at addr occupies the least-significant bits.
  - Store response carries rdata=0 and err=0.
- Errors:
  - Conditions that set rsp_err=1:
    - Half access with addr[0]=1.
    - Word access with addr[1:0]!=0.
    - Load funct3 011/110/111.
    - Store funct3 other than 000/001/010.
  - On error: no memory write, rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err registered and held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. rsp_valid drops the next cycle and rsp_rdata/rsp_err clear to 0.
  - req_ready stays 0 in RESP; there is no response/request overlap.
- Request stability: the holding registers decouple the inputs. req_* may change after acceptance with no effect.
- Address wrap: addresses are taken modulo 2^A_WIDTH, so a byte access at the top address is legal. Word accesses can never straddle the top because alignment is enforced.
- Reset mid-operation (WAIT or RESP): the pending request is dropped with no response. If rst_n asserts before the access edge, no write occurs.
- Memory reads return the contents current at the access edge. A store followed by a load to the same address returns the new data.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Enum dmem_state_t {IDLE, WAIT, RESP}.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module load_store_align (combinational).
  - Store path: from funct3, addr[1:0] and wdata, produces 4-bit byte enables and lane-shifted write data.
  - Load path: from the raw 32-bit word, produces the extracted and extended rdata.
- The top level holds the FSM, counter, holding registers and byte-lane memory array.

Test Plan:
- LATENCY=2:
  - Stimulus: SW 0xDEADBEEF @0x100, then LW @0x100.
  - Required: each rsp_valid appears 3 cycles after acceptance. The load returns 0xDEADBEEF with err=0.
- Sign/zero extension:
  - Stimulus: SB 0x80 @0x203, then LB @0x203 and LBU @0x203; SH 0x8001 @0x202, then LH @0x202 and LHU @0x202.
  - Required: LB returns 0xFFFFFF80 and LBU returns 0x00000080. LH returns 0xFFFF8001 and LHU returns 0x00008001.
- Misalignment:
  - Stimulus: SW @0x101, then LW @0x100 (word previously 0xDEADBEEF); also LH @0x101.
  - Required: the store gets err=1 and memory is unchanged, so the LW still returns 0xDEADBEEF. The LH gets err=1 with rdata=0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_valid, rdata and err stay stable and req_ready=0. req_ready returns to 1 the cycle after rsp_ready goes high.
- Reset mid-WAIT:
  - Stimulus: SW 0x12345678 @0x40 (old contents 0), then pulse rst_n low during WAIT; afterwards LW @0x40.
  - Required: no response during or after reset, all outputs 0 during reset, and the LW returns 0 (no write occurred).
- LATENCY=0 and wrap:
  - Stimulus: with LATENCY=0, SB 0xAA @0x0001FFFF, then LBU @0xFFFFFFFF (A_WIDTH=17).
  - Required: response 1 cycle after acceptance. LBU returns 0x000000AA.
